// File: rtl/rmi_node_arbiter_if.sv
// rmi_node_arbiter_if
//   Bundles the adapter-side (up_*) and node-side (nd_*) achannel signals
//   of rmi_node_arbiter, plus the static per-node instance IDs.
//   Optional macro: RMI_ARB_DROP_CNT_EN adds drop_cnt_o (unmatched RX count).
//
//   Modports:
//     slave  - the arbiter's view (drives *_o, reads *_i)
//     master - the surrounding environment's view (adapter + nodes)
//
//   Signals:
//     up_rx_z_i / up_rx_vz_i / up_rx_lz_o   adapter RX message, valid, taken
//     up_tx_z_o / up_tx_lz_o / up_tx_vz_i   adapter TX message, offered, accepted
//     nd_rx_z_o / nd_rx_vz_o / nd_rx_lz_i   per-node RX data, valid, read
//     nd_tx_z_i / nd_tx_lz_i / nd_tx_vz_o   per-node TX data, request, grant
//     iid_i                                 per-node instance IDs
//     grant_o                               one-hot owner of the TX holding register
interface rmi_node_arbiter_if #(
    parameter int unsigned N_NODES      = 4,
    parameter int unsigned RMI_MSG_SIZE = 80,
    parameter int unsigned IID_SIZE     = 8
);
    logic [RMI_MSG_SIZE-1:0]         up_rx_z_i;
    logic                            up_rx_vz_i;
    logic                            up_rx_lz_o;
    logic [RMI_MSG_SIZE-1:0]         up_tx_z_o;
    logic                            up_tx_lz_o;
    logic                            up_tx_vz_i;
    logic [N_NODES*RMI_MSG_SIZE-1:0] nd_rx_z_o;
    logic [N_NODES-1:0]              nd_rx_vz_o;
    logic [N_NODES-1:0]              nd_rx_lz_i;
    logic [N_NODES*RMI_MSG_SIZE-1:0] nd_tx_z_i;
    logic [N_NODES-1:0]              nd_tx_lz_i;
    logic [N_NODES-1:0]              nd_tx_vz_o;
    logic [N_NODES*IID_SIZE-1:0]     iid_i;
    logic [N_NODES-1:0]              grant_o;
`ifdef RMI_ARB_DROP_CNT_EN
    logic [7:0]                      drop_cnt_o;
`endif

    modport slave (
        input  up_rx_z_i, up_rx_vz_i, up_tx_vz_i,
        input  nd_rx_lz_i, nd_tx_z_i, nd_tx_lz_i, iid_i,
        output up_rx_lz_o, up_tx_z_o, up_tx_lz_o,
        output nd_rx_z_o, nd_rx_vz_o, nd_tx_vz_o, grant_o
`ifdef RMI_ARB_DROP_CNT_EN
        , output drop_cnt_o
`endif
    );

    modport master (
        output up_rx_z_i, up_rx_vz_i, up_tx_vz_i,
        output nd_rx_lz_i, nd_tx_z_i, nd_tx_lz_i, iid_i,
        input  up_rx_lz_o, up_tx_z_o, up_tx_lz_o,
        input  nd_rx_z_o, nd_rx_vz_o, nd_tx_vz_o, grant_o
`ifdef RMI_ARB_DROP_CNT_EN
        , input drop_cnt_o
`endif
    );
endinterface

// File: rtl/rmi_node_arbiter.sv
// rmi_node_arbiter
//   Shares one RTSNoC achannel adapter port among N_NODES RMI component nodes.
//   TX: round-robin arbitration of node requests into a single holding
//       register which is then offered to the adapter.
//   RX: each adapter message is dispatched to the lowest-index node whose
//       instance ID matches the message's IID field; unmatched ones are dropped.
//   Optional macro: RMI_ARB_DROP_CNT_EN adds an 8-bit saturating drop counter
//   (drop_cnt_o) on the interface.
//
//   Ports:
//     clk_i  clock
//     rst_i  synchronous active-high reset
//     bus    rmi_node_arbiter_if.slave (adapter and node channels, IIDs, grant)
module rmi_node_arbiter #(
    parameter int unsigned N_NODES      = 4,
    parameter int unsigned RMI_MSG_SIZE = 80,
    parameter int unsigned IID_SIZE     = 8,
    parameter int unsigned IID_LSB      = 64
) (
    input logic               clk_i,
    input logic               rst_i,
    rmi_node_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(N_NODES);

    localparam logic [0:0] T_IDLE    = 1'b0;
    localparam logic [0:0] T_SEND    = 1'b1;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DELIVER = 1'b1;

    logic [0:0]              tx_state;
    logic [0:0]              rx_state;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           tx_idx;
    logic [PW-1:0]           tx_sel;
    logic                    tx_found;
    logic [N_NODES-1:0]      tx_onehot;
    logic [N_NODES-1:0]      grant;
    logic [RMI_MSG_SIZE-1:0] tx_data;
    logic [RMI_MSG_SIZE-1:0] tx_hold;
    logic [PW-1:0]           rx_idx;
    logic [PW-1:0]           rx_sel;
    logic                    rx_match;
    logic [N_NODES-1:0]      rx_onehot;
    logic [RMI_MSG_SIZE-1:0] rx_buf;
    logic [IID_SIZE-1:0]     rx_iid;
`ifdef RMI_ARB_DROP_CNT_EN
    logic [7:0]              drop_cnt;
`endif

    // First requester at or above rr_ptr, scanning with wrap-around.
    always_comb begin : tx_pick
        int unsigned j;
        logic [PW-1:0] cand;
        tx_found = 1'b0;
        tx_sel   = '0;
        j        = 0;
        cand     = '0;
        for (int unsigned i = 0; i < N_NODES; i++) begin
            j = 32'(rr_ptr) + i;
            if (j >= N_NODES) j = j - N_NODES;
            cand = PW'(j);
            if (!tx_found && bus.nd_tx_lz_i[cand]) begin
                tx_found = 1'b1;
                tx_sel   = cand;
            end
        end
        tx_onehot         = '0;
        tx_onehot[tx_sel] = 1'b1;
        tx_data           = '0;
        for (int unsigned i = 0; i < N_NODES; i++) begin
            if (tx_sel == PW'(i)) tx_data = bus.nd_tx_z_i[i*RMI_MSG_SIZE +: RMI_MSG_SIZE];
        end
    end

    // Lowest-index node whose IID matches the incoming message.
    always_comb begin : rx_pick
        rx_iid   = bus.up_rx_z_i[IID_LSB +: IID_SIZE];
        rx_match = 1'b0;
        rx_sel   = '0;
        for (int unsigned k = 0; k < N_NODES; k++) begin
            if (!rx_match && bus.iid_i[k*IID_SIZE +: IID_SIZE] == rx_iid) begin
                rx_match = 1'b1;
                rx_sel   = PW'(k);
            end
        end
        rx_onehot         = '0;
        rx_onehot[rx_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= T_IDLE;
            rr_ptr   <= '0;
            tx_idx   <= '0;
            grant    <= '0;
            tx_hold  <= '0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_found) begin
                        tx_hold  <= tx_data;
                        tx_idx   <= tx_sel;
                        grant    <= tx_onehot;
                        tx_state <= T_SEND;
                    end
                end
                default: begin
                    if (bus.up_tx_vz_i) begin
                        grant    <= '0;
                        rr_ptr   <= (tx_idx == PW'(N_NODES-1)) ? '0 : tx_idx + 1'b1;
                        tx_state <= T_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= R_IDLE;
            rx_idx   <= '0;
            rx_buf   <= '0;
`ifdef RMI_ARB_DROP_CNT_EN
            drop_cnt <= '0;
`endif
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (bus.up_rx_vz_i) begin
                        rx_buf <= bus.up_rx_z_i;
                        if (rx_match) begin
                            rx_idx   <= rx_sel;
                            rx_state <= R_DELIVER;
                        end
`ifdef RMI_ARB_DROP_CNT_EN
                        else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    if (bus.nd_rx_lz_i[rx_idx]) rx_state <= R_IDLE;
                end
            endcase
        end
    end

    // Combinational handshake pulses are suppressed during the reset cycle.
    assign bus.nd_tx_vz_o = (!rst_i && tx_state == T_IDLE && tx_found) ? tx_onehot : '0;
    assign bus.up_rx_lz_o = !rst_i && rx_state == R_IDLE && bus.up_rx_vz_i;
    assign bus.up_tx_lz_o = (tx_state == T_SEND);
    assign bus.up_tx_z_o  = tx_hold;
    assign bus.grant_o    = grant;
    assign bus.nd_rx_vz_o = (rx_state == R_DELIVER) ? rx_onehot : '0;
    assign bus.nd_rx_z_o  = {N_NODES{rx_buf}};
`ifdef RMI_ARB_DROP_CNT_EN
    assign bus.drop_cnt_o = drop_cnt;
`endif
endmodule

// File: tb/tb_rmi_node_arbiter.sv
// tb_rmi_node_arbiter
//   Directed bench for rmi_node_arbiter (N_NODES=4, 80-bit messages,
//   8-bit IID at bit 64). Stimulus pushes expected grants / TX messages /
//   RX deliveries into queues; a monitor pops them at each DUT handshake.
//   Honours RMI_ARB_DROP_CNT_EN for the drop-counter checks.
module tb_rmi_node_arbiter;
    localparam int N  = 4;
    localparam int W  = 80;
    localparam int IW = 8;
    localparam int LSB = 64;

    typedef struct {
        int           node;
        logic [W-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rmi_node_arbiter_if #(.N_NODES(N), .RMI_MSG_SIZE(W), .IID_SIZE(IW)) bus ();

    rmi_node_arbiter #(
        .N_NODES(N), .RMI_MSG_SIZE(W), .IID_SIZE(IW), .IID_LSB(LSB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    grant_q[$];
    item_t tx_q[$];
    item_t rx_q[$];

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] oh(input int k);
        logic [N*W-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] mk_msg(input logic [IW-1:0] iid, input logic [63:0] pl);
        logic [W-1:0] m;
        m = '0;
        m[LSB +: IW] = iid;
        m[63:0] = pl;
        return m;
    endfunction

    task automatic set_tx(input int k, input logic [W-1:0] d);
        bus.nd_tx_z_i[k*W +: W] = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake.
    initial begin
        item_t it;
        int    g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.nd_tx_vz_o != '0) begin
                    if (grant_q.size() == 0) chk("grant_unexpected", bus.nd_tx_vz_o, '0);
                    else begin
                        g = grant_q.pop_front();
                        chk("grant_node", bus.nd_tx_vz_o, oh(g));
                    end
                end
                if (bus.up_tx_lz_o && bus.up_tx_vz_i) begin
                    if (tx_q.size() == 0) chk("tx_unexpected", bus.up_tx_z_o, '0);
                    else begin
                        it = tx_q.pop_front();
                        chk("tx_data", bus.up_tx_z_o, it.data);
                        chk("tx_owner", bus.grant_o, oh(it.node));
                    end
                end
                if ((bus.nd_rx_vz_o & bus.nd_rx_lz_i) != '0) begin
                    if (rx_q.size() == 0) chk("rx_unexpected", bus.nd_rx_vz_o, '0);
                    else begin
                        it = rx_q.pop_front();
                        chk("rx_node", bus.nd_rx_vz_o, oh(it.node));
                        for (int s = 0; s < N; s++)
                            chk("rx_slice", bus.nd_rx_z_o[s*W +: W], it.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] m;

        rst = 1'b1;
        bus.up_rx_z_i  = '0;
        bus.up_rx_vz_i = 1'b0;
        bus.up_tx_vz_i = 1'b0;
        bus.nd_rx_lz_i = '0;
        bus.nd_tx_z_i  = '0;
        bus.nd_tx_lz_i = '0;
        bus.iid_i      = {8'd4, 8'd3, 8'd2, 8'd1};

        // Reset state, and no pulses while reset is held
        next();
        bus.up_rx_vz_i = 1'b1;
        bus.up_rx_z_i  = mk_msg(8'd1, 64'h99);
        bus.nd_tx_lz_i = 4'b0001;
        samp();
        chk("rst_up_tx_lz", bus.up_tx_lz_o, 0);
        chk("rst_up_tx_z", bus.up_tx_z_o, 0);
        chk("rst_up_rx_lz", bus.up_rx_lz_o, 0);
        chk("rst_nd_rx_vz", bus.nd_rx_vz_o, 0);
        chk("rst_nd_rx_z", bus.nd_rx_z_o, 0);
        chk("rst_nd_tx_vz", bus.nd_tx_vz_o, 0);
        chk("rst_grant", bus.grant_o, 0);
`ifdef RMI_ARB_DROP_CNT_EN
        chk("rst_drop_cnt", bus.drop_cnt_o, 0);
`endif
        next();
        rst = 1'b0;
        bus.up_rx_vz_i = 1'b0;
        bus.nd_tx_lz_i = '0;

        // Single request from node 2, upstream stalls 3 cycles
        set_tx(2, 80'hAB);
        bus.nd_tx_lz_i = 4'b0100;
        grant_q.push_back(2);
        tx_q.push_back('{node: 2, data: 80'hAB});
        samp();
        chk("t1_grant_comb", bus.nd_tx_vz_o, 4'b0100);
        chk("t1_lz_c0", bus.up_tx_lz_o, 0);
        next();
        bus.nd_tx_lz_i = '0;
        for (int c = 0; c < 3; c++) begin
            samp();
            chk("t1_lz_hold", bus.up_tx_lz_o, 1);
            chk("t1_z_hold", bus.up_tx_z_o, 80'hAB);
            chk("t1_grant_o", bus.grant_o, 4'b0100);
            chk("t1_no_regrant", bus.nd_tx_vz_o, 0);
            next();
        end
        bus.up_tx_vz_i = 1'b1;
        samp();
        next();
        bus.up_tx_vz_i = 1'b0;
        samp();
        chk("t1_grant_clear", bus.grant_o, 0);
        chk("t1_lz_clear", bus.up_tx_lz_o, 0);

        // Round-robin with all nodes requesting continuously
        next();
        do_reset();
        for (int k = 0; k < N; k++) set_tx(k, W'(8'h10 + k));
        bus.nd_tx_lz_i = 4'hF;
        bus.up_tx_vz_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            grant_q.push_back(order[i]);
            tx_q.push_back('{node: order[i], data: W'(8'h10 + order[i])});
        end
        for (int c = 0; c < 10; c++) begin
            samp();
            if (c % 2 == 0) begin
                chk("rr_grant", bus.nd_tx_vz_o, oh(order[c/2]));
                chk("rr_lz_idle", bus.up_tx_lz_o, 0);
            end else begin
                chk("rr_no_grant", bus.nd_tx_vz_o, 0);
                chk("rr_lz_send", bus.up_tx_lz_o, 1);
            end
            next();
        end
        bus.nd_tx_lz_i = '0;
        bus.up_tx_vz_i = 1'b0;

        // RX dispatch to node 2 (IID 3), foreign read ignored
        m = mk_msg(8'd3, 64'h1122334455667788);
        bus.up_rx_z_i  = m;
        bus.up_rx_vz_i = 1'b1;
        rx_q.push_back('{node: 2, data: m});
        samp();
        chk("rx_take", bus.up_rx_lz_o, 1);
        chk("rx_vz_c0", bus.nd_rx_vz_o, 0);
        next();
        bus.up_rx_vz_i = 1'b0;
        bus.nd_rx_lz_i = 4'b0001;
        samp();
        chk("rx_take_done", bus.up_rx_lz_o, 0);
        chk("rx_vz_c1", bus.nd_rx_vz_o, 4'b0100);
        chk("rx_z_c1", bus.nd_rx_z_o[W-1:0], m);
        next();
        samp();
        chk("rx_vz_foreign_read", bus.nd_rx_vz_o, 4'b0100);
        next();
        bus.nd_rx_lz_i = 4'b0100;
        samp();
        next();
        bus.nd_rx_lz_i = '0;
        samp();
        chk("rx_vz_clear", bus.nd_rx_vz_o, 0);

        // Drops of an unowned IID, one per cycle
        next();
        bus.up_rx_vz_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.up_rx_z_i = mk_msg(8'h7F, 64'(i));
            samp();
            chk("drop_take", bus.up_rx_lz_o, 1);
            chk("drop_no_vz", bus.nd_rx_vz_o, 0);
            next();
        end
        bus.up_rx_vz_i = 1'b0;
        samp();
        chk("drop_no_vz_after", bus.nd_rx_vz_o, 0);
`ifdef RMI_ARB_DROP_CNT_EN
        chk("drop_cnt_3", bus.drop_cnt_o, 3);
`endif
        next();
        bus.up_rx_vz_i = 1'b1;
        for (int i = 0; i < 297; i++) next();
        bus.up_rx_vz_i = 1'b0;
        samp();
        chk("drop_many_no_vz", bus.nd_rx_vz_o, 0);
`ifdef RMI_ARB_DROP_CNT_EN
        chk("drop_cnt_sat", bus.drop_cnt_o, 255);
`endif

        // Concurrent TX/RX, duplicate IID 3 on nodes 1 and 2
        next();
        bus.iid_i = {8'd4, 8'd3, 8'd3, 8'd1};
        do_reset();
        set_tx(3, 80'h5555);
        bus.nd_tx_lz_i = 4'b1000;
        m = mk_msg(8'd3, 64'hCAFE);
        bus.up_rx_z_i  = m;
        bus.up_rx_vz_i = 1'b1;
        grant_q.push_back(3);
        tx_q.push_back('{node: 3, data: 80'h5555});
        rx_q.push_back('{node: 1, data: m});
        samp();
        chk("cc_grant", bus.nd_tx_vz_o, 4'b1000);
        chk("cc_rx_take", bus.up_rx_lz_o, 1);
        next();
        bus.nd_tx_lz_i = '0;
        bus.up_rx_vz_i = 1'b0;
        bus.up_tx_vz_i = 1'b1;
        bus.nd_rx_lz_i = 4'b0010;
        samp();
        chk("cc_tx_lz", bus.up_tx_lz_o, 1);
        chk("cc_rx_vz_dup", bus.nd_rx_vz_o, 4'b0010);
        next();
        bus.up_tx_vz_i = 1'b0;
        bus.nd_rx_lz_i = '0;
        samp();
        chk("cc_grant_clear", bus.grant_o, 0);
        chk("cc_rx_clear", bus.nd_rx_vz_o, 0);

        // Reset mid-send: first move rr_ptr to 1 via node 0
        next();
        set_tx(0, 80'h0A);
        bus.nd_tx_lz_i = 4'b0001;
        bus.up_tx_vz_i = 1'b1;
        grant_q.push_back(0);
        tx_q.push_back('{node: 0, data: 80'h0A});
        samp();
        next();
        bus.nd_tx_lz_i = '0;
        samp();
        next();
        bus.up_tx_vz_i = 1'b0;
        set_tx(2, 80'h0C);
        bus.nd_tx_lz_i = 4'b0100;
        grant_q.push_back(2);
        samp();
        next();
        bus.nd_tx_lz_i = '0;
        rst = 1'b1;
        samp();
        next();
        rst = 1'b0;
        samp();
        chk("mr_lz", bus.up_tx_lz_o, 0);
        chk("mr_grant", bus.grant_o, 0);
        chk("mr_hold", bus.up_tx_z_o, 0);
        // rr_ptr back at 0: node 0 wins over node 2
        next();
        bus.nd_tx_lz_i = 4'b0101;
        bus.up_tx_vz_i = 1'b1;
        grant_q.push_back(0);
        tx_q.push_back('{node: 0, data: 80'h0A});
        samp();
        chk("mr_rr_zero", bus.nd_tx_vz_o, 4'b0001);
        next();
        bus.nd_tx_lz_i = '0;
        samp();
        next();
        bus.up_tx_vz_i = 1'b0;
        set_tx(1, 80'h0B);
        bus.nd_tx_lz_i = 4'b0010;
        bus.up_tx_vz_i = 1'b1;
        grant_q.push_back(1);
        tx_q.push_back('{node: 1, data: 80'h0B});
        samp();
        next();
        bus.nd_tx_lz_i = '0;
        samp();
        next();
        bus.up_tx_vz_i = 1'b0;
        samp();
        chk("mr_final_grant", bus.grant_o, 0);

        next();
        next();
        samp();
        chk("end_grant_q", grant_q.size(), 0);
        chk("end_tx_q", tx_q.size(), 0);
        chk("end_rx_q", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
